// File: rtl/box_plot_arbiter.sv
// Shares the VGA pixel-write port between two 4x4 box requesters and a screen clear.
// Build option PLOT_ARB_ROUND_ROBIN_EN: round-robin A/B arbitration (default: A over B).
module box_plot_arbiter #(
   parameter int X_SCREEN_PIXELS = 160,
   parameter int Y_SCREEN_PIXELS = 120
) (
   input  logic       iClock,
   input  logic       iReset,
   input  logic       iReqA,
   input  logic       iReqB,
   input  logic [7:0] iXA,
   input  logic [7:0] iXB,
   input  logic [6:0] iYA,
   input  logic [6:0] iYB,
   input  logic [2:0] iColourA,
   input  logic [2:0] iColourB,
   output logic       oAckA,
   output logic       oAckB,
   output logic       oDoneA,
   output logic       oDoneB,
   input  logic       iClearReq,
   output logic       oClearAck,
   output logic       oClearDone,
   output logic [7:0] oX,
   output logic [6:0] oY,
   output logic [2:0] oColour,
   output logic       oPlot
);

   localparam logic [8:0] XLIM = 9'(X_SCREEN_PIXELS);
   localparam logic [7:0] YLIM = 8'(Y_SCREEN_PIXELS);
   localparam logic [7:0] XMAX = 8'(X_SCREEN_PIXELS - 1);
   localparam logic [6:0] YMAX = 7'(Y_SCREEN_PIXELS - 1);

   typedef enum logic [1:0] {S_IDLE, S_BOX, S_CLEAR} state_t;

   state_t     state_q, state_d;
   logic [7:0] bx_q, bx_d;
   logic [6:0] by_q, by_d;
   logic [2:0] bcol_q, bcol_d;
   logic       owner_q, owner_d;
   logic [3:0] c_q, c_d;
   logic [7:0] cx_q, cx_d;
   logic [6:0] cy_q, cy_d;
   logic       last_q, last_d;
   logic       pend_a_q, pend_a_d, pend_b_q, pend_b_d, pend_c_q, pend_c_d;
   logic [7:0] x_q, x_d;
   logic [6:0] y_q, y_d;
   logic [2:0] col_q, col_d;
   logic       plot_q, plot_d;
   logic       ack_a_q, ack_a_d, ack_b_q, ack_b_d, ack_c_q, ack_c_d;
   logic       done_a_q, done_a_d, done_b_q, done_b_d, done_c_q, done_c_d;

   logic       req_a, req_b, req_c, grant_b;
   logic [8:0] px;
   logic [7:0] py;
   logic       pin;

   // A request held past its ack cycle is latched so it is served at the next IDLE.
   assign req_a = iReqA | pend_a_q;
   assign req_b = iReqB | pend_b_q;
   assign req_c = iClearReq | pend_c_q;

`ifdef PLOT_ARB_ROUND_ROBIN_EN
   logic rr_q;
   assign grant_b = req_b & (~req_a | rr_q);

   always_ff @(posedge iClock) begin
      if (iReset)
         rr_q <= 1'b0;
      else if (state_q == S_IDLE && !req_c && (req_a || req_b))
         rr_q <= ~grant_b;
   end
`else
   assign grant_b = req_b & ~req_a;
`endif

   assign px  = {1'b0, bx_q} + {7'd0, c_q[1:0]};
   assign py  = {1'b0, by_q} + {6'd0, c_q[3:2]};
   assign pin = (px < XLIM) && (py < YLIM);

   always_comb begin
      state_d  = state_q;
      bx_d     = bx_q;
      by_d     = by_q;
      bcol_d   = bcol_q;
      owner_d  = owner_q;
      c_d      = c_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      last_d   = last_q;
      pend_a_d = pend_a_q | iReqA;
      pend_b_d = pend_b_q | iReqB;
      pend_c_d = pend_c_q | iClearReq;
      x_d      = x_q;
      y_d      = y_q;
      col_d    = col_q;
      plot_d   = 1'b0;
      ack_a_d  = 1'b0;
      ack_b_d  = 1'b0;
      ack_c_d  = 1'b0;
      done_a_d = 1'b0;
      done_b_d = 1'b0;
      done_c_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_c) begin
               state_d  = S_CLEAR;
               cx_d     = '0;
               cy_d     = '0;
               last_d   = 1'b0;
               ack_c_d  = 1'b1;
               pend_c_d = 1'b0;
            end else if (req_a || req_b) begin
               state_d = S_BOX;
               c_d     = '0;
               last_d  = 1'b0;
               owner_d = grant_b;
               if (grant_b) begin
                  bx_d     = iXB;
                  by_d     = iYB;
                  bcol_d   = iColourB;
                  ack_b_d  = 1'b1;
                  pend_b_d = 1'b0;
               end else begin
                  bx_d     = iXA;
                  by_d     = iYA;
                  bcol_d   = iColourA;
                  ack_a_d  = 1'b1;
                  pend_a_d = 1'b0;
               end
            end
         end
         S_BOX: begin
            if (last_q) begin
               state_d  = S_IDLE;
               done_a_d = ~owner_q;
               done_b_d = owner_q;
            end else begin
               plot_d = pin;
               if (pin) begin
                  x_d   = px[7:0];
                  y_d   = py[6:0];
                  col_d = bcol_q;
               end
               c_d = c_q + 4'd1;
               if (c_q == 4'd15)
                  last_d = 1'b1;
            end
         end
         S_CLEAR: begin
            if (last_q) begin
               state_d  = S_IDLE;
               done_c_d = 1'b1;
            end else begin
               plot_d = 1'b1;
               x_d    = cx_q;
               y_d    = cy_q;
               col_d  = '0;
               if (cx_q == XMAX) begin
                  cx_d = '0;
                  if (cy_q == YMAX)
                     last_d = 1'b1;
                  else
                     cy_d = cy_q + 7'd1;
               end else begin
                  cx_d = cx_q + 8'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q  <= S_IDLE;
         bx_q     <= '0;
         by_q     <= '0;
         bcol_q   <= '0;
         owner_q  <= 1'b0;
         c_q      <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         last_q   <= 1'b0;
         pend_a_q <= 1'b0;
         pend_b_q <= 1'b0;
         pend_c_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         col_q    <= '0;
         plot_q   <= 1'b0;
         ack_a_q  <= 1'b0;
         ack_b_q  <= 1'b0;
         ack_c_q  <= 1'b0;
         done_a_q <= 1'b0;
         done_b_q <= 1'b0;
         done_c_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         bx_q     <= bx_d;
         by_q     <= by_d;
         bcol_q   <= bcol_d;
         owner_q  <= owner_d;
         c_q      <= c_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         last_q   <= last_d;
         pend_a_q <= pend_a_d;
         pend_b_q <= pend_b_d;
         pend_c_q <= pend_c_d;
         x_q      <= x_d;
         y_q      <= y_d;
         col_q    <= col_d;
         plot_q   <= plot_d;
         ack_a_q  <= ack_a_d;
         ack_b_q  <= ack_b_d;
         ack_c_q  <= ack_c_d;
         done_a_q <= done_a_d;
         done_b_q <= done_b_d;
         done_c_q <= done_c_d;
      end
   end

   assign oX         = x_q;
   assign oY         = y_q;
   assign oColour    = col_q;
   assign oPlot      = plot_q;
   assign oAckA      = ack_a_q;
   assign oAckB      = ack_b_q;
   assign oClearAck  = ack_c_q;
   assign oDoneA     = done_a_q;
   assign oDoneB     = done_b_q;
   assign oClearDone = done_c_q;

endmodule

// File: tb/tb_box_plot_arbiter.sv
// Directed self-checking bench for box_plot_arbiter; expectations follow the
// PLOT_ARB_ROUND_ROBIN_EN setting used for the build.
module tb_box_plot_arbiter;

   logic       clk = 1'b0;
   logic       iReset = 1'b1;
   logic       iReqA = 1'b0, iReqB = 1'b0, iClearReq = 1'b0;
   logic [7:0] iXA = '0, iXB = '0;
   logic [6:0] iYA = '0, iYB = '0;
   logic [2:0] iColourA = '0, iColourB = '0;
   logic       oAckA, oAckB, oDoneA, oDoneB, oClearAck, oClearDone, oPlot;
   logic [7:0] oX;
   logic [6:0] oY;
   logic [2:0] oColour;

   int checks = 0;
   int errors = 0;

   box_plot_arbiter #(.X_SCREEN_PIXELS(160), .Y_SCREEN_PIXELS(120)) dut (
      .iClock(clk), .iReset(iReset),
      .iReqA(iReqA), .iReqB(iReqB),
      .iXA(iXA), .iXB(iXB), .iYA(iYA), .iYB(iYB),
      .iColourA(iColourA), .iColourB(iColourB),
      .oAckA(oAckA), .oAckB(oAckB), .oDoneA(oDoneA), .oDoneB(oDoneB),
      .iClearReq(iClearReq), .oClearAck(oClearAck), .oClearDone(oClearDone),
      .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot)
   );

   always #5 clk = ~clk;

   // Advance one edge and sample just after it.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [24:0] v;
      iReset = 1'b1; iReqA = 1'b1; iClearReq = 1'b1;
      step; step;
      v = {oX, oY, oColour, oPlot, oAckA, oAckB, oDoneA, oDoneB, oClearAck, oClearDone};
      checks++;
      if (v !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", v); end
      iReqA = 1'b0; iClearReq = 1'b0; iReset = 1'b0;
      step;
      checks++;
      if ({oAckA, oClearAck, oPlot} !== 3'b000) begin
         errors++; $display("FAIL reset_req_ignored got %b exp 000", {oAckA, oClearAck, oPlot});
      end
   endtask

   task automatic test_box_basic;
      logic [19:0] e;
      iXA = 8'd10; iYA = 7'd20; iColourA = 3'd5; iReqA = 1'b1;
      step;
      checks++;
      if (oAckA !== 1'b1) begin errors++; $display("FAIL basic_ack got %b exp 1", oAckA); end
      iReqA = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step;
         e = {1'b0, 1'b1, 8'(10 + i % 4), 7'(20 + i / 4), 3'd5};
         checks++;
         if ({oAckA, oPlot, oX, oY, oColour} !== e) begin
            errors++;
            $display("FAIL basic_pixel%0d got %h exp %h", i, {oAckA, oPlot, oX, oY, oColour}, e);
         end
      end
      step;
      checks++;
      if ({oDoneA, oDoneB, oPlot} !== 3'b100) begin
         errors++; $display("FAIL basic_done got %b exp 100", {oDoneA, oDoneB, oPlot});
      end
      step;
      checks++;
      if (oDoneA !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", oDoneA); end
   endtask

   task automatic test_arbitration;
      int ord[6];
      int expo[6];
      int n = 0, na = 0, nb = 0;
      bit seen = 0;
`ifdef PLOT_ARB_ROUND_ROBIN_EN
      expo = '{0, 1, 0, 1, 0, 1};
`else
      expo = '{0, 0, 0, 1, 1, 1};
`endif
      ord = '{-1, -1, -1, -1, -1, -1};
      iXA = 8'd30; iYA = 7'd30; iColourA = 3'd1;
      iXB = 8'd60; iYB = 7'd60; iColourB = 3'd2;
      iReqA = 1'b1; iReqB = 1'b1;
      for (int t = 0; t < 300 && n < 6; t++) begin
         step;
         if (oAckA === 1'b1) begin ord[n] = 0; n++; na++; if (na == 3) iReqA = 1'b0; end
         if (oAckB === 1'b1) begin ord[n] = 1; n++; nb++; if (nb == 3) iReqB = 1'b0; end
      end
      checks++;
      if (n != 6) begin errors++; $display("FAIL arb_grant_count got %0d exp 6", n); end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (ord[k] != expo[k]) begin
            errors++; $display("FAIL arb_order%0d got %0d exp %0d (0=A 1=B)", k, ord[k], expo[k]);
         end
      end
      for (int t = 0; t < 40 && !seen; t++) begin
         step;
         if (oDoneB === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL arb_final_done got 0 exp 1"); end
   endtask

   task automatic test_clip;
      logic [18:0] e;
      logic [7:0]  hx = 8'd0;
      logic [6:0]  hy = 7'd0;
      bit          pl;
      iXA = 8'd158; iYA = 7'd118; iColourA = 3'd6; iReqA = 1'b1;
      step;
      checks++;
      if (oAckA !== 1'b1) begin errors++; $display("FAIL clip_ack got %b exp 1", oAckA); end
      iReqA = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step;
         pl = (i % 4 < 2) && (i / 4 < 2);
         if (pl) begin hx = 8'(158 + i % 4); hy = 7'(118 + i / 4); end
         e = {pl, hx, hy, 3'd6};
         checks++;
         if ({oPlot, oX, oY, oColour} !== e) begin
            errors++;
            $display("FAIL clip_pixel%0d got %h exp %h", i, {oPlot, oX, oY, oColour}, e);
         end
      end
      step;
      checks++;
      if (oDoneA !== 1'b1) begin errors++; $display("FAIL clip_done got %b exp 1", oDoneA); end
   endtask

   task automatic test_clear_vs_box;
      int bad = 0;
      int plots = 0;
      iXB = 8'd5; iYB = 7'd6; iColourB = 3'd2;
      iClearReq = 1'b1; iReqB = 1'b1;
      step;
      checks++;
      if ({oClearAck, oAckB} !== 2'b10) begin
         errors++; $display("FAIL clear_ack got %b exp 10", {oClearAck, oAckB});
      end
      iClearReq = 1'b0;
      for (int i = 0; i < 19200; i++) begin
         step;
         if ({oAckB, oPlot, oX, oY, oColour} !== {1'b0, 1'b1, 8'(i % 160), 7'(i / 160), 3'd0}) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL clear_pixels got %0d bad exp 0", bad); end
      checks++;
      if ({oX, oY} !== {8'd159, 7'd119}) begin
         errors++; $display("FAIL clear_last got %0d,%0d exp 159,119", oX, oY);
      end
      step;
      checks++;
      if ({oClearDone, oAckB, oPlot} !== 3'b100) begin
         errors++; $display("FAIL clear_done got %b exp 100", {oClearDone, oAckB, oPlot});
      end
      step;
      checks++;
      if (oAckB !== 1'b1) begin errors++; $display("FAIL clear_then_ackB got %b exp 1", oAckB); end
      iReqB = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step;
         if (oPlot === 1'b1) plots++;
      end
      checks++;
      if (plots != 16) begin errors++; $display("FAIL clear_boxB_plots got %0d exp 16", plots); end
      step;
      checks++;
      if (oDoneB !== 1'b1) begin errors++; $display("FAIL clear_boxB_done got %b exp 1", oDoneB); end
   endtask

   task automatic test_reset_mid;
      logic [24:0] v;
      int da_cnt = 0, da_t = -1, ab_t = -1, db_t = -1;
      iXA = 8'd40; iYA = 7'd50; iColourA = 3'd7; iReqA = 1'b1;
      step;
      iReqA = 1'b0;
      for (int i = 0; i < 7; i++) step;
      checks++;
      if ({oPlot, oX, oY} !== {1'b1, 8'd42, 7'd51}) begin
         errors++; $display("FAIL rmid_pixel7 got %h exp %h", {oPlot, oX, oY}, {1'b1, 8'd42, 7'd51});
      end
      iReset = 1'b1;
      step;
      v = {oX, oY, oColour, oPlot, oAckA, oAckB, oDoneA, oDoneB, oClearAck, oClearDone};
      checks++;
      if (v !== '0) begin errors++; $display("FAIL rmid_outputs got %h exp 0", v); end
      iReset = 1'b0;
      iXB = 8'd70; iYB = 7'd80; iColourB = 3'd4;
      iReqA = 1'b1; iReqB = 1'b1;
      step;
      checks++;
      if ({oAckA, oAckB} !== 2'b10) begin
         errors++; $display("FAIL rmid_A_first got %b exp 10", {oAckA, oAckB});
      end
      iReqA = 1'b0;
      for (int t = 1; t <= 40; t++) begin
         step;
         if (oDoneA === 1'b1) begin da_cnt++; da_t = t; end
         if (oAckB === 1'b1) begin ab_t = t; iReqB = 1'b0; end
         if (oDoneB === 1'b1) db_t = t;
      end
      checks++;
      if (da_cnt != 1 || da_t != 17) begin
         errors++; $display("FAIL rmid_doneA got %0d pulses at %0d exp 1 at 17", da_cnt, da_t);
      end
      checks++;
      if (ab_t != 18) begin errors++; $display("FAIL rmid_ackB_time got %0d exp 18", ab_t); end
      checks++;
      if (db_t != 35) begin errors++; $display("FAIL rmid_doneB_time got %0d exp 35", db_t); end
   endtask

   task automatic test_back_to_back;
      int acks = 0, dones = 0, plots = 0, ack2_t = -1, done2_t = -1;
      iXB = 8'd0; iYB = 7'd0; iColourB = 3'd1; iReqB = 1'b1;
      step;
      checks++;
      if (oAckB !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got %b exp 1", oAckB); end
      for (int t = 1; t <= 40; t++) begin
         step;
         if (t == 2) iReqB = 1'b0;
         if (oAckB === 1'b1) begin acks++; ack2_t = t; end
         if (oDoneB === 1'b1) begin dones++; done2_t = t; end
         if (oPlot === 1'b1) plots++;
      end
      checks++;
      if (acks != 1 || ack2_t != 18) begin
         errors++; $display("FAIL b2b_ack2 got %0d acks at %0d exp 1 at 18", acks, ack2_t);
      end
      checks++;
      if (dones != 2 || done2_t != 35) begin
         errors++; $display("FAIL b2b_dones got %0d last %0d exp 2 last 35", dones, done2_t);
      end
      checks++;
      if (plots != 32) begin errors++; $display("FAIL b2b_plots got %0d exp 32", plots); end
   endtask

   initial begin
      test_reset;
      test_box_basic;
      test_arbitration;
      test_clip;
      test_clear_vs_box;
      test_reset_mid;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
